// File: rtl/rr_bus_arbiter.sv
// Four-requester round-robin arbiter for a shared tri-state bus. Each tenure is limited to
// MAX_HOLD cycles and is followed by one turnaround cycle in which every buffer is released.

module rr_bus_arbiter_chk (
  input logic       clk,
  input logic       rst,
  input logic [3:0] gnt
);

  // At most one buffer enable may be active in any cycle.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
    $countones(gnt) <= 1)
    else $error("rr_bus_arbiter_chk: more than one gnt bit set (gnt=%b)", gnt);

  // A change of grantee must pass through a gnt=0000 turnaround cycle.
  a_gnt_turn : assert property (@(posedge clk) disable iff (rst)
    (gnt != 4'b0000 && $past(gnt) != 4'b0000) |-> (gnt == $past(gnt)))
    else $error("rr_bus_arbiter_chk: grantee switch without turnaround (gnt=%b)", gnt);

endmodule

module rr_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [3:0] r_hold;
  logic [3:0] w_hold_nxt;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       r_preempt;
  logic       w_preempt_nxt;
  logic [2:0] w_pick;

  // Returns {found, index} of the first set request scanning upward from ptr_v, modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
    logic [1:0] idx;
    logic       found;
    logic [1:0] win;
    found = 1'b0;
    win   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_v + 2'(i);
      if (!found && req_v[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_gnt_nxt     = 4'b0000;
    w_busy_nxt    = 1'b0;
    w_preempt_nxt = 1'b0;
    w_pick        = rr_pick(req, r_ptr);
    case (r_state)
      S_IDLE, S_TURN: begin
        if (w_pick[2]) begin
          w_state_nxt = S_GRANT;
          w_sel_nxt   = w_pick[1:0];
          w_hold_nxt  = 4'd0;
          w_gnt_nxt   = 4'b0001 << w_pick[1:0];
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        // A release on the last allowed cycle is a normal release, not a preemption.
        if (!req[r_sel] || (r_hold == HOLD_LAST)) begin
          w_state_nxt   = S_TURN;
          w_ptr_nxt     = r_sel + 2'd1;
          w_hold_nxt    = 4'd0;
          w_preempt_nxt = req[r_sel];
        end else begin
          w_hold_nxt = r_hold + 4'd1;
          w_gnt_nxt  = 4'b0001 << r_sel;
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= 2'd0;
      r_ptr     <= 2'd0;
      r_hold    <= 4'd0;
      r_gnt     <= 4'b0000;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_gnt     <= w_gnt_nxt;
      r_busy    <= w_busy_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign preempt = r_preempt;

  rr_bus_arbiter_chk u_chk (
    .clk (clk),
    .rst (rst),
    .gnt (r_gnt)
  );

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed self-checking bench for rr_bus_arbiter with hand-computed expected outputs.

module tb_rr_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  int n_checks;
  int n_pass;

  rr_bus_arbiter #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                            input logic e_busy, input logic e_pre);
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".preempt"}, 32'(preempt), 32'(e_pre));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("reset.ptr", 32'(dut.r_ptr), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] one;
    one      = 4'b0001;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    tick();

    // Single requester, three-cycle tenure, voluntary release.
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("single.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick();
    expect_out("single.turn", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    expect_out("single.idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    chk("single.ptr", 32'(dut.r_ptr), 32'd3);

    // All requesting: rotation 0,1,2,3,0 with MAX_HOLD preemption each tenure.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 8; k++) begin
        tick();
        expect_out("rr.grant", one << (g % 4), 2'(g % 4), 1'b1, 1'b0);
      end
      tick();
      expect_out("rr.turn", 4'b0000, 2'(g % 4), 1'b0, 1'b1);
    end

    // ptr=2 with requesters 0 and 3: 3 wins first; other req bits ignored during GRANT.
    do_reset();
    req = 4'b0010;
    tick();
    expect_out("ptr2.g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("ptr2.turn", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    expect_out("ptr2.idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    req = 4'b1001;
    tick();
    expect_out("ptr2.g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b1111;
    tick();
    expect_out("ptr2.g3_other", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0001;
    tick();
    expect_out("ptr2.turn3", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    expect_out("ptr2.g0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Requester 1 preempted under req=0011, then requester 0 releases on its last cycle.
    do_reset();
    req = 4'b0001;
    tick();
    expect_out("pre.g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    tick();
    expect_out("pre.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      tick();
      expect_out("pre.g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    expect_out("pre.turn", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    expect_out("pre.g0b", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick();
      expect_out("pre.g0hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req = 4'b0010;
    tick();
    expect_out("pre.last_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("pre.g1b", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Reset in the middle of a tenure, then immediate re-arbitration from ptr=0.
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    expect_out("midrst.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    expect_out("midrst.reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("midrst.ptr", 32'(dut.r_ptr), 32'd0);
    rst = 1'b0;
    tick();
    expect_out("midrst.regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
